// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FP32 field layout, rounding-mode encodings, flag bit
// positions and the operand classes used by the float-to-integer converter.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  localparam int FLG_INV = 1;
  localparam int FLG_INX = 0;

  // CLS_BIG marks finite operands whose integer part cannot fit even before rounding.
  typedef enum logic [1:0] {
    CLS_NUM,
    CLS_NAN,
    CLS_INF,
    CLS_BIG
  } ftoi_cls_e;

endpackage

// File: rtl/ftoi_round.sv
// Combinational magnitude rounder for the float-to-integer converter.
// Increments the truncated magnitude according to rm, guard, sticky and sign.
module ftoi_round
  import fpu_pkg::*;
#(
  parameter int W = 33
) (
  input  logic [W-1:0] mag,
  input  logic         guard,
  input  logic         sticky,
  input  logic         sign,
  input  logic [1:0]   rm,
  output logic [W-1:0] rmag,
  output logic         cout
);

  logic inc;

  // Directed modes round the magnitude away from zero only on the side they point to.
  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = guard & (sticky | mag[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (guard | sticky);
      default: inc = ~sign & (guard | sticky);
    endcase
  end

  assign {cout, rmag} = {1'b0, mag} + {{W{1'b0}}, inc};

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage pipelined FP32 -> integer converter with valid/ready handshake.
// Define FTOI_FLAGS_EN to add the out_flags port ({invalid, inexact}).
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter int OUT_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [1:0]       in_rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y
`ifdef FTOI_FLAGS_EN
  ,
  output logic [1:0]       out_flags
`endif
);

  // One extra integer bit keeps 2^OUT_W representable so overflow is seen after rounding.
  localparam int IW = OUT_W + 1;
  localparam int AW = IW + MAN_W + 1;

  localparam logic [EXP_W:0]   BIG_E    = (EXP_W + 1)'(BIAS + IW);
  localparam logic [EXP_W-1:0] EXP_MAX  = '1;
  localparam logic [EXP_W-1:0] EXP_HALF = EXP_W'(BIAS - 1);

  localparam logic [OUT_W-1:0] MAX_POS = (SIGNED != 0) ? {1'b0, {(OUT_W-1){1'b1}}}
                                                       : {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] MIN_VAL = (SIGNED != 0) ? {1'b1, {(OUT_W-1){1'b0}}}
                                                       : {OUT_W{1'b0}};
  localparam logic [OUT_W+1:0] POS_LIM = {2'b00, MAX_POS};
  localparam logic [OUT_W+1:0] NEG_LIM = {2'b00, MIN_VAL};

  logic adv;

  logic                 x_sign;
  logic [EXP_W-1:0]     x_exp;
  logic [MAN_W-1:0]     x_man;
  logic [AW-1:0]        x_wide;
  logic [IW-1:0]        a_mag;
  logic                 a_guard;
  logic                 a_sticky;
  ftoi_cls_e            a_cls;

  logic                 s1_valid;
  logic                 s1_sign;
  logic [IW-1:0]        s1_mag;
  logic                 s1_guard;
  logic                 s1_sticky;
  logic [1:0]           s1_rm;
  ftoi_cls_e            s1_cls;

  logic [IW-1:0]        r_mag;
  logic                 r_cout;
  logic [OUT_W+1:0]     full;
  logic                 inv;
  logic [OUT_W-1:0]     y_raw;
  logic [OUT_W-1:0]     y_sat;
  logic [OUT_W-1:0]     y_n;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign x_sign = in_x[EXP_W+MAN_W];
  assign x_exp  = in_x[EXP_W+MAN_W-1:MAN_W];
  assign x_man  = in_x[MAN_W-1:0];

  // Fixed point with 24 fraction bits: shifting by e-126 puts the 2^-1 weight at bit MAN_W.
  always_comb begin
    a_cls    = CLS_NUM;
    a_mag    = '0;
    a_guard  = 1'b0;
    a_sticky = 1'b0;
    x_wide   = '0;
    if (x_exp == EXP_MAX) begin
      a_cls = (x_man != '0) ? CLS_NAN : CLS_INF;
    end else if ({1'b0, x_exp} >= BIG_E) begin
      a_cls = CLS_BIG;
    end else if (x_exp >= EXP_HALF) begin
      x_wide   = {{IW{1'b0}}, 1'b1, x_man} << (x_exp - EXP_HALF);
      a_mag    = x_wide[AW-1:MAN_W+1];
      a_guard  = x_wide[MAN_W];
      a_sticky = |x_wide[MAN_W-1:0];
    end else begin
      a_sticky = (x_exp != '0) || (x_man != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      s1_sign   <= x_sign;
      s1_mag    <= a_mag;
      s1_guard  <= a_guard;
      s1_sticky <= a_sticky;
      s1_rm     <= in_rm;
      s1_cls    <= a_cls;
    end
  end

  ftoi_round #(
    .W(IW)
  ) u_round (
    .mag    (s1_mag),
    .guard  (s1_guard),
    .sticky (s1_sticky),
    .sign   (s1_sign),
    .rm     (s1_rm),
    .rmag   (r_mag),
    .cout   (r_cout)
  );

  assign full = {r_cout, r_mag};

  // Unsigned builds have MIN_VAL=0, so a negative value rounding to nonzero saturates to 0.
  always_comb begin
    inv   = (s1_cls != CLS_NUM) || (s1_sign ? (full > NEG_LIM) : (full > POS_LIM));
    y_raw = s1_sign ? -full[OUT_W-1:0] : full[OUT_W-1:0];
    y_sat = ((s1_cls == CLS_NAN) || !s1_sign) ? MAX_POS : MIN_VAL;
    y_n   = inv ? y_sat : y_raw;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y <= y_n;
      end
    end
  end

`ifdef FTOI_FLAGS_EN
  logic inx;

  assign inx = (s1_guard | s1_sticky) & ~inv;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_flags <= '0;
    end else if (adv && s1_valid) begin
      out_flags[FLG_INV] <= inv;
      out_flags[FLG_INX] <= inx;
    end
  end
`endif

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed bench for ftoi_pipe: a 32-bit signed instance and a 16-bit unsigned one.
// Flag checks are compiled in only when FTOI_FLAGS_EN is defined.
module tb_ftoi_pipe;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  logic        v32 = 1'b0, or32 = 1'b1, r32, ov32;
  logic [31:0] x32 = '0, y32;
  logic [1:0]  rm32 = RM_RNE, f32w;
  logic        v16 = 1'b0, or16 = 1'b1, r16, ov16;
  logic [31:0] x16 = '0;
  logic [15:0] y16;
  logic [1:0]  rm16 = RM_RNE, f16w;

  int checks = 0;
  int failures = 0;
  int acc;
  logic fired;
  logic [33:0] q32[$];
  logic [33:0] q16[$];

`ifdef FTOI_FLAGS_EN
  logic [1:0] f32, f16;
  assign f32w = f32;
  assign f16w = f16;
`else
  assign f32w = 2'b00;
  assign f16w = 2'b00;
`endif

  ftoi_pipe #(.OUT_W(32), .SIGNED(1)) dut32 (
    .clk(clk), .rstn(rstn), .in_valid(v32), .in_ready(r32), .in_x(x32), .in_rm(rm32),
    .out_valid(ov32), .out_ready(or32), .out_y(y32)
`ifdef FTOI_FLAGS_EN
    , .out_flags(f32)
`endif
  );

  ftoi_pipe #(.OUT_W(16), .SIGNED(0)) dut16 (
    .clk(clk), .rstn(rstn), .in_valid(v16), .in_ready(r16), .in_x(x16), .in_rm(rm16),
    .out_valid(ov16), .out_ready(or16), .out_y(y16)
`ifdef FTOI_FLAGS_EN
    , .out_flags(f16)
`endif
  );

  // Results are collected mid-cycle, when the transfer is about to happen.
  always @(negedge clk) begin
    if (rstn && ov32 && or32) q32.push_back({f32w, y32});
    if (rstn && ov16 && or16) q16.push_back({f16w, 16'h0000, y16});
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [31:0] x, input logic [1:0] rm);
    if (sel == 0) begin
      x32 = x; rm32 = rm; v32 = 1'b1;
    end else begin
      x16 = x; rm16 = rm; v16 = 1'b1;
    end
    for (int i = 0; i < 20 && !((sel == 0) ? r32 : r16); i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    v32 = 1'b0;
    v16 = 1'b0;
  endtask

  task automatic runVector(input int sel, input string tag, input logic [31:0] x,
                           input logic [1:0] rm, input logic [31:0] ey, input logic [1:0] ef);
    logic [33:0] r;
    applyStimulus(sel, x, rm);
    for (int i = 0; i < 10 && ((sel == 0) ? q32.size() : q16.size()) == 0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput({tag, ":cnt"}, (sel == 0) ? q32.size() : q16.size(), 1);
    if (((sel == 0) ? q32.size() : q16.size()) > 0) begin
      r = (sel == 0) ? q32.pop_front() : q16.pop_front();
      checkOutput({tag, ":y"}, r[31:0], ey);
`ifdef FTOI_FLAGS_EN
      checkOutput({tag, ":f"}, r[33:32], ef);
`else
      if (ef > 2'd3) checkOutput({tag, ":f"}, ef, 0);
`endif
    end
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst:ov32", ov32, 0);
    checkOutput("rst:y32", y32, 0);
    checkOutput("rst:ir32", r32, 1);
    checkOutput("rst:ov16", ov16, 0);
    checkOutput("rst:y16", y16, 0);
`ifdef FTOI_FLAGS_EN
    checkOutput("rst:f32", f32, 0);
`endif
    rstn = 1'b1;
    @(posedge clk); #1;

    runVector(0, "2.5rne",  32'h40200000, RM_RNE, 32'd2, 2'b01);
    runVector(0, "2.5rtz",  32'h40200000, RM_RTZ, 32'd2, 2'b01);
    runVector(0, "2.5rdn",  32'h40200000, RM_RDN, 32'd2, 2'b01);
    runVector(0, "2.5rup",  32'h40200000, RM_RUP, 32'd3, 2'b01);
    runVector(0, "-2.5rne", 32'hC0200000, RM_RNE, 32'hFFFFFFFE, 2'b01);
    runVector(0, "-2.5rdn", 32'hC0200000, RM_RDN, 32'hFFFFFFFD, 2'b01);
    runVector(0, "-2.5rup", 32'hC0200000, RM_RUP, 32'hFFFFFFFE, 2'b01);
    runVector(0, "1.5rne",  32'h3FC00000, RM_RNE, 32'd2, 2'b01);
    runVector(0, "1.0",     32'h3F800000, RM_RNE, 32'd1, 2'b00);
    runVector(0, "-1.0",    32'hBF800000, RM_RNE, 32'hFFFFFFFF, 2'b00);
    runVector(0, "2^31",    32'h4F000000, RM_RTZ, 32'h7FFFFFFF, 2'b10);
    runVector(0, "-2^31",   32'hCF000000, RM_RTZ, 32'h80000000, 2'b00);
    runVector(0, "<-2^31",  32'hCF000001, RM_RTZ, 32'h80000000, 2'b10);
    runVector(0, "maxfit",  32'h4EFFFFFF, RM_RTZ, 32'h7FFFFF80, 2'b00);
    runVector(0, "nan",     32'h7FC00000, RM_RNE, 32'h7FFFFFFF, 2'b10);
    runVector(0, "+inf",    32'h7F800000, RM_RNE, 32'h7FFFFFFF, 2'b10);
    runVector(0, "-inf",    32'hFF800000, RM_RNE, 32'h80000000, 2'b10);
    runVector(0, "-0rdn",   32'h80000000, RM_RDN, 32'd0, 2'b00);
    runVector(0, "-0.5rdn", 32'hBF000000, RM_RDN, 32'hFFFFFFFF, 2'b01);
    runVector(0, "-0.5rne", 32'hBF000000, RM_RNE, 32'd0, 2'b01);
    runVector(0, "0.5+rup", 32'h3F000001, RM_RUP, 32'd1, 2'b01);
    runVector(0, "-dnrdn",  32'h80000001, RM_RDN, 32'hFFFFFFFF, 2'b01);
    runVector(0, "+dnrup",  32'h00000001, RM_RUP, 32'd1, 2'b01);
    runVector(0, "+dnrdn",  32'h00000001, RM_RDN, 32'd0, 2'b01);

    // Backpressure: consumer stalls during cycles 2..6 of a six-operand stream.
    q32.delete();
    acc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      or32 = !(cyc >= 2 && cyc <= 6);
      v32  = (acc < 6);
      x32  = 32'h3F800000 + ((acc < 6) ? 32'(acc) * 32'h00800000 : 32'h0);
      rm32 = RM_RTZ;
      #1;
      if (cyc == 1) checkOutput("bp:ov_c1", ov32, 0);
      if (cyc == 2) begin
        checkOutput("bp:ov_c2", ov32, 1);
        checkOutput("bp:ir_c2", r32, 0);
      end
      if (cyc == 6) checkOutput("bp:inflight", 64'(acc - q32.size()), 2);
      fired = v32 && r32;
      @(posedge clk); #1;
      if (fired) acc++;
      if (acc == 6 && q32.size() == 6) break;
    end
    v32  = 1'b0;
    or32 = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("bp:count", q32.size(), 6);
    // Inputs were 1.0, 2.0, 4.0, 8.0, 16.0, 32.0 (exponent stepped by one each time).
    for (int i = 0; i < 6; i++) begin
      if (i < q32.size()) checkOutput($sformatf("bp:y%0d", i), q32[i][31:0], 64'd1 << i);
    end
    q32.delete();

    // Reset with two operands in flight and the consumer stalled.
    or32 = 1'b0;
    rm32 = RM_RTZ;
    v32  = 1'b1;
    x32  = 32'h40E00000;
    @(posedge clk); #1;
    x32  = 32'h41000000;
    @(posedge clk); #1;
    v32  = 1'b0;
    checkOutput("rst2:pre_ov", ov32, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    checkOutput("rst2:ov", ov32, 0);
    checkOutput("rst2:y", y32, 0);
    or32 = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("rst2:drop", q32.size(), 0);
    runVector(0, "rst2:9.0", 32'h41100000, RM_RTZ, 32'd9, 2'b00);

    // 16-bit unsigned instance.
    runVector(1, "u16:65535",  32'h477FFF00, RM_RTZ, 32'h0000FFFF, 2'b00);
    runVector(1, "u16:65536",  32'h47800000, RM_RTZ, 32'h0000FFFF, 2'b10);
    runVector(1, "u16:-3",     32'hC0400000, RM_RTZ, 32'h00000000, 2'b10);
    runVector(1, "u16:-0.4",   32'hBECCCCCD, RM_RNE, 32'h00000000, 2'b01);
    runVector(1, "u16:1000.5", 32'h447A2000, RM_RNE, 32'h000003E8, 2'b01);
    runVector(1, "u16:-inf",   32'hFF800000, RM_RNE, 32'h00000000, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
